// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline controller.
//   pipe_mode_e : controller state, also driven out as the pipe_mode word
//   PIPE_MODE_W : width of pipe_mode
//   stage_mask  : stage index -> thermometer mask (bits 0..idx), saturating
package pipe_ctrl_pkg;

  localparam int PIPE_MODE_W = 3;

  typedef enum logic [PIPE_MODE_W-1:0] {
    PM_RESET  = 3'b000,
    PM_RUN    = 3'b001,
    PM_STALL  = 3'b010,
    PM_FLUSH  = 3'b011,
    PM_DRAIN  = 3'b100,
    PM_HALTED = 3'b101
  } pipe_mode_e;

  // Bits 0..idx set, clipped to n stages; an idx at or beyond the last stage
  // gives all n bits. Callers cast the result down to their stage count (<= 32).
  function automatic logic [31:0] stage_mask(input int unsigned idx,
                                             input int unsigned n);
    logic [31:0] m;
    for (int unsigned i = 0; i < 32; i++) m[i] = (i <= idx) && (i < n);
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_flush_seq.sv
// Flush sequencer: holds the flush mask for FLUSH_CYCLES cycles per request,
// merges masks of back-to-back requests and keeps the flush epoch.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : accepted flush request this cycle
//   i_mask       : stage mask for the new request
//   o_busy       : flush continues past the current cycle
//   o_flush      : registered per-stage flush mask
//   o_epoch      : flush epoch, +1 per accepted request, wraps
import pipe_ctrl_pkg::*;

module pipe_ctrl_flush_seq #(
  parameter int NUM_STAGES   = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int EPOCH_W      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NUM_STAGES-1:0] i_mask,
  output logic                  o_busy,
  output logic [NUM_STAGES-1:0] o_flush,
  output logic [EPOCH_W-1:0]    o_epoch
);

  localparam int CNT_W = 4;

  // r_cnt = flush cycles left including the one currently on the outputs
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_STAGES-1:0] r_mask;
  logic [EPOCH_W-1:0]    r_epoch;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_mask  <= '0;
      r_epoch <= '0;
    end else if (i_start) begin
      // a request landing mid-flush widens the mask and restarts the hold
      r_cnt   <= CNT_W'(FLUSH_CYCLES);
      r_mask  <= ((r_cnt != '0) ? r_mask : '0) | i_mask;
      r_epoch <= r_epoch + 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) r_mask <= '0;
    end
  end

  assign o_busy  = (r_cnt > CNT_W'(1));
  assign o_flush = r_mask;
  assign o_epoch = r_epoch;

endmodule

// File: rtl/pipe_ctrl.sv
// Front-end pipeline controller: per-stage stall/flush, multi-cycle flush
// with epoch tag, and drain/halt for debug quiescing.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_res_full         : per-resource full flags
//   i_flush_req        : flush request pulse
//   i_flush_stage      : flush stages 0..i_flush_stage (saturating)
//   i_halt_req         : level, drain then halt
//   i_pipe_empty       : ROB and front-end empty
//   o_stall, o_flush   : per-stage hold / invalidate
//   o_pipe_mode        : current state (pipe_mode_e encoding)
//   o_epoch, o_halted  : flush epoch, halted flag
// Optional build macro PIPE_CTRL_PERF_EN adds saturating 32-bit counters
//   o_perf_stall_cnt / o_perf_flush_cnt / o_perf_halt_cnt.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter int NUM_STAGES   = 3,
  parameter int NUM_RES      = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int EPOCH_W      = 3,
  localparam int FS_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_RES-1:0]     i_res_full,
  input  logic                   i_flush_req,
  input  logic [FS_W-1:0]        i_flush_stage,
  input  logic                   i_halt_req,
  input  logic                   i_pipe_empty,
  output logic [NUM_STAGES-1:0]  o_stall,
  output logic [NUM_STAGES-1:0]  o_flush,
  output logic [PIPE_MODE_W-1:0] o_pipe_mode,
  output logic [EPOCH_W-1:0]     o_epoch,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]            o_perf_stall_cnt,
  output logic [31:0]            o_perf_flush_cnt,
  output logic [31:0]            o_perf_halt_cnt,
`endif
  output logic                   o_halted
);

  pipe_mode_e            r_state, w_nxt, w_run_nxt;
  logic [NUM_STAGES-1:0] r_stall, w_stall_nxt, w_mask;
  logic                  r_halt_pend;
  logic                  w_res_any, w_start, w_busy;

  assign w_res_any = |i_res_full;
  assign w_run_nxt = w_res_any ? PM_STALL : PM_RUN;
  // HALTED and RESET ignore flush requests
  assign w_start   = i_flush_req && (r_state == PM_RUN  || r_state == PM_STALL ||
                                     r_state == PM_FLUSH || r_state == PM_DRAIN);
  assign w_mask    = NUM_STAGES'(stage_mask(32'(i_flush_stage), NUM_STAGES));

  pipe_ctrl_flush_seq #(
    .NUM_STAGES  (NUM_STAGES),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .EPOCH_W     (EPOCH_W)
  ) u_flush_seq (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(w_start),
    .i_mask (w_mask),
    .o_busy (w_busy),
    .o_flush(o_flush),
    .o_epoch(o_epoch)
  );

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= PM_RESET;
      r_stall     <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_stall     <= w_stall_nxt;
      // a halt seen while flushing is remembered until the flush ends
      r_halt_pend <= (w_nxt == PM_FLUSH) ? (r_halt_pend | i_halt_req) : 1'b0;
    end
  end

  // next state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      PM_RESET: w_nxt = w_run_nxt;
      PM_RUN, PM_STALL: begin
        if (i_flush_req)     w_nxt = PM_FLUSH;
        else if (i_halt_req) w_nxt = PM_DRAIN;
        else                 w_nxt = w_run_nxt;
      end
      PM_FLUSH: begin
        if (i_flush_req || w_busy)        w_nxt = PM_FLUSH;
        else if (r_halt_pend || i_halt_req) w_nxt = PM_DRAIN;
        else                              w_nxt = w_run_nxt;
      end
      PM_DRAIN: begin
        if (i_flush_req)       w_nxt = PM_FLUSH;
        else if (!i_halt_req)  w_nxt = w_run_nxt;
        else if (i_pipe_empty) w_nxt = PM_HALTED;
      end
      PM_HALTED: if (!i_halt_req) w_nxt = w_run_nxt;
      default:   w_nxt = PM_RESET;
    endcase
  end

  // outputs: stall is computed for the next state and registered with it
  always_comb begin
    w_stall_nxt = '0;
    case (w_nxt)
      PM_STALL, PM_FLUSH, PM_HALTED: w_stall_nxt = '1;
      PM_DRAIN: begin
        w_stall_nxt    = {NUM_STAGES{w_res_any}};
        w_stall_nxt[0] = 1'b1;
      end
      default: w_stall_nxt = '0;
    endcase
  end

  assign o_stall     = r_stall;
  assign o_pipe_mode = r_state;
  assign o_halted    = (r_state == PM_HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall, r_perf_flush, r_perf_halt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_halt  <= '0;
    end else begin
      if (r_state == PM_STALL && !(&r_perf_stall))  r_perf_stall <= r_perf_stall + 1'b1;
      if (w_start && !(&r_perf_flush))              r_perf_flush <= r_perf_flush + 1'b1;
      if (r_state == PM_HALTED && !(&r_perf_halt))  r_perf_halt  <= r_perf_halt + 1'b1;
    end
  end

  assign o_perf_stall_cnt = r_perf_stall;
  assign o_perf_flush_cnt = r_perf_flush;
  assign o_perf_halt_cnt  = r_perf_halt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random traffic, every cycle
// compared against a behavioural model of the controller's rules.
module tb_pipe_ctrl;

  localparam int NS = 3, NR = 4, FC = 2, EW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] res_full = '0;
  logic          flush_req = 1'b0;
  logic [1:0]    flush_stage = '0;
  logic          halt_req = 1'b0;
  logic          pipe_empty = 1'b0;
  logic [NS-1:0] stall, flush;
  logic [2:0]    pipe_mode;
  logic [EW-1:0] epoch;
  logic          halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_flush_cnt, perf_halt_cnt;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.NUM_STAGES(NS), .NUM_RES(NR), .FLUSH_CYCLES(FC), .EPOCH_W(EW)) dut (
    .i_clk(clk), .i_rst(rst), .i_res_full(res_full), .i_flush_req(flush_req),
    .i_flush_stage(flush_stage), .i_halt_req(halt_req), .i_pipe_empty(pipe_empty),
    .o_stall(stall), .o_flush(flush), .o_pipe_mode(pipe_mode), .o_epoch(epoch),
`ifdef PIPE_CTRL_PERF_EN
    .o_perf_stall_cnt(perf_stall_cnt), .o_perf_flush_cnt(perf_flush_cnt),
    .o_perf_halt_cnt(perf_halt_cnt),
`endif
    .o_halted(halted)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: modes as plain ints (0 reset,1 run,2 stall,3 flush,4 drain,5 halted);
  // m_left = flush cycles still to show, counting the one on the outputs.
  int m_mode = 0, m_left = 0, m_mask = 0, m_epoch = 0, m_stall = 0;
  bit m_pend = 0;
  longint m_pstall = 0, m_pflush = 0, m_phalt = 0;

  task automatic model_step();
    int rs, nm, fsat, left;
    bit take;
    if (rst) begin
      m_mode = 0; m_left = 0; m_mask = 0; m_epoch = 0; m_stall = 0; m_pend = 0;
      m_pstall = 0; m_pflush = 0; m_phalt = 0;
      return;
    end
    rs   = (res_full != 0) ? 2 : 1;
    take = flush_req && (m_mode >= 1 && m_mode <= 4);
    if (m_mode == 2 && m_pstall < 64'hFFFF_FFFF) m_pstall++;
    if (m_mode == 5 && m_phalt  < 64'hFFFF_FFFF) m_phalt++;
    if (take && m_pflush < 64'hFFFF_FFFF) m_pflush++;
    if (take) begin
      fsat    = (int'(flush_stage) > NS - 1) ? NS - 1 : int'(flush_stage);
      m_mask  = ((m_left > 0) ? m_mask : 0) | ((1 << (fsat + 1)) - 1);
      left    = FC;
      m_epoch = (m_epoch + 1) % (1 << EW);
    end else begin
      left = (m_left > 0) ? m_left - 1 : 0;
      if (left == 0) m_mask = 0;
    end
    case (m_mode)
      0:       nm = rs;
      1, 2:    nm = flush_req ? 3 : halt_req ? 4 : rs;
      3:       nm = take ? 3 : (left > 0) ? 3 : (m_pend || halt_req) ? 4 : rs;
      4:       nm = flush_req ? 3 : !halt_req ? rs : pipe_empty ? 5 : 4;
      default: nm = halt_req ? 5 : rs;
    endcase
    m_pend  = (nm == 3) && (m_pend || halt_req);
    m_left  = left;
    m_mode  = nm;
    m_stall = (nm == 2 || nm == 3 || nm == 5) ? (1 << NS) - 1 :
              (nm == 4) ? ((res_full != 0) ? (1 << NS) - 1 : 1) : 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("mode",   32'(pipe_mode), 32'(m_mode));
    chk("stall",  32'(stall),     32'(m_stall));
    chk("flush",  32'(flush),     32'(m_mask));
    chk("epoch",  32'(epoch),     32'(m_epoch));
    chk("halted", 32'(halted),    32'(m_mode == 5));
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", perf_stall_cnt, 32'(m_pstall));
    chk("perf_flush", perf_flush_cnt, 32'(m_pflush));
    chk("perf_halt",  perf_halt_cnt,  32'(m_phalt));
`endif
  endtask

  initial begin
    // reset
    rst = 1'b1; cycle(); cycle();
    chk("rst_mode", 32'(pipe_mode), 32'h0);
    rst = 1'b0; cycle();
    // resource stall for 3 cycles
    res_full = 4'b0100; repeat (3) cycle();
    chk("stall_all", 32'(stall), 32'h7);
    res_full = '0; cycle();
    chk("run_stall0", 32'(stall), 32'h0);
    cycle();
    // flush stage 1, then stage 2 on the second flush cycle
    flush_req = 1'b1; flush_stage = 2'd1; cycle();
    chk("flush_011", 32'(flush), 32'h3);
    chk("epoch_1",   32'(epoch), 32'h1);
    flush_req = 1'b0; cycle();
    flush_req = 1'b1; flush_stage = 2'd2; cycle();
    chk("flush_111", 32'(flush), 32'h7);
    chk("epoch_2",   32'(epoch), 32'h2);
    flush_req = 1'b0; repeat (3) cycle();
    // drain then halt
    halt_req = 1'b1; repeat (3) cycle();
    chk("drain_mode", 32'(pipe_mode), 32'h4);
    pipe_empty = 1'b1; cycle();
    chk("halted", 32'(halted), 32'h1);
    flush_req = 1'b1; cycle();   // ignored while halted
    flush_req = 1'b0;
    halt_req = 1'b0; pipe_empty = 1'b0; cycle();
    chk("resume_run", 32'(pipe_mode), 32'h1);
    // eight flushes wrap the epoch back to its starting value
    for (int i = 0; i < 8; i++) begin
      flush_req = 1'b1; flush_stage = 2'(i); cycle();
      flush_req = 1'b0; cycle(); cycle();
    end
    chk("epoch_wrap", 32'(epoch), 32'h2);
    // reset in the middle of a flush
    flush_req = 1'b1; flush_stage = 2'd3; cycle();
    flush_req = 1'b0; rst = 1'b1; cycle();
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_epoch", 32'(epoch), 32'h0);
    rst = 1'b0; cycle();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 249) == 0);
      res_full    = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
      flush_req   = ($urandom_range(0, 7) == 0);
      flush_stage = 2'($urandom);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      pipe_empty  = ($urandom_range(0, 3) == 0);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised main pipeline controller for the out-of-order core. It replaces the fixed fetch/decode/dispatch stall and flush logic with per-stage stall and flush vectors over `NUM_STAGES` front-end stages, and takes any number of resource-full inputs. It adds multi-cycle flush sequencing with a flush epoch tag, plus a drain/halt mode for debug and vector-context quiescing. It sits between the resource trackers (RS, ROB, LSQ, vector queues), the branch unit, and the front-end stage registers.

## Interface
- `NUM_STAGES`, 3: front-end stages controlled; index 0 = fetch, `NUM_STAGES-1` = dispatch.
- `NUM_RES`, 4: resource-full inputs.
- `FLUSH_CYCLES`, 2: cycles the flush vector is held asserted; legal range 1..15.
- `EPOCH_W`, 3: flush epoch counter width.
- `clk`, in, 1: single clock; every output is registered on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `res_full`, in, `NUM_RES`: a 1 on any bit means that resource cannot accept a dispatch.
- `flush_req`, in, 1: pulse from the branch unit or exception unit requesting a flush.
- `flush_stage`, in, `$clog2(NUM_STAGES)`: youngest-to-oldest bound; stages 0..`flush_stage` are flushed. Sampled only when `flush_req` is 1.
- `halt_req`, in, 1: level; requests a drain followed by a halt.
- `pipe_empty`, in, 1: the ROB and all front-end stages are empty.
- `stall`, out, `NUM_STAGES`: per-stage hold.
- `flush`, out, `NUM_STAGES`: per-stage invalidate.
- `pipe_mode`, out, 3: 000 RESET, 001 RUN, 010 STALL, 011 FLUSH, 100 DRAIN, 101 HALTED.
- `epoch`, out, `EPOCH_W`: current flush epoch.
- `halted`, out, 1: high in the HALTED state.

## Operation
- FSM states equal the `pipe_mode` values. Outputs decode from the registered state and registered masks.
- RESET:
  - Entered while `rst` is high.
  - The first cycle after `rst` falls goes to RUN or STALL according to `res_full`.
- RUN and STALL:
  - Any `res_full` bit = 1 selects STALL; otherwise RUN.
  - In STALL, `stall` is all ones; in RUN, `stall` is all zeros.
- FLUSH:
  - `flush_req` from RUN, STALL or DRAIN enters FLUSH.
  - `flush` = mask of bits 0..`flush_stage` held for `FLUSH_CYCLES` cycles.
  - `stall` is all ones throughout.
  - `epoch` increments by 1 on entry and wraps modulo 2^`EPOCH_W`.
  - On exit, go to DRAIN if a halt is pending, otherwise to RUN or STALL per `res_full`.
- DRAIN:
  - `halt_req` from RUN or STALL enters DRAIN.
  - `stall[0]` = 1 (fetch held); the other stages follow `res_full` as in RUN/STALL.
  - `pipe_empty` = 1 goes to HALTED.
- HALTED:
  - `stall` is all ones and `halted` = 1.
  - `halt_req` = 0 returns to RUN or STALL.
  - `flush_req` in HALTED is ignored.
- Priority, highest first: `rst`, `flush_req`, `halt_req`, `res_full`.
- Boundary behaviour:
  - `flush_req` during FLUSH restarts the counter, ORs the new mask into the current one, and increments `epoch` again.
  - `halt_req` rising during FLUSH is latched as a pending halt.
  - `halt_req` dropping in DRAIN before `pipe_empty` returns to RUN or STALL.
  - `flush_stage` ≥ `NUM_STAGES` saturates to all ones.

## Timing
- Reset values: `stall` 0, `flush` 0, `pipe_mode` 000, `epoch` 0, `halted` 0, pending halt 0, flush counter 0.
- Latency: input to output is 1 cycle.
  - `res_full` rising at edge N gives `stall` = all ones after edge N+1.
  - `flush_req` at edge N gives `flush` high from edge N+1 through edge N+`FLUSH_CYCLES`.
  - The following cycle leaves FLUSH.
- `epoch` changes in the same cycle that `flush` first rises.
- HALTED is reached 1 cycle after `pipe_empty` is sampled high in DRAIN.
- `rst` during any state returns to RESET at the next edge; pending halt, masks and the counter are cleared.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Adds outputs `perf_stall_cnt`, `perf_flush_cnt` and `perf_halt_cnt` (32 bits each).
  - They count cycles in STALL, flush entries, and cycles in HALTED respectively.
  - They saturate at all ones and reset to 0.
- `PIPE_CTRL_PERF_EN` undefined: these ports and the counter logic do not exist; all other behaviour is identical.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - `pipe_mode_e` enum with the encodings above.
  - `PIPE_MODE_W = 3`.
  - A `stage_mask` function: index to a thermometer mask with saturation.
- Sub-module `pipe_ctrl_flush_seq`: flush counter, mask merge and epoch register, with start/busy handshake to the FSM.

## Test plan
- Reset, then `res_full` = 0100 for 3 cycles → `stall` = 111 and mode 010 one cycle later for 3 cycles, then back to 001 with `stall` = 000.
- `flush_req` with `flush_stage` = 1, `FLUSH_CYCLES` = 2 → `flush` = 011 for exactly 2 cycles, `stall` = 111 during them, `epoch` goes 0→1.
- Second `flush_req` with `flush_stage` = 2 on the 2nd flush cycle → `flush` = 111 for 2 more cycles; `epoch` = 2.
- `halt_req` = 1 → mode 100 and `stall[0]` = 1; after `pipe_empty` = 1, mode 101 and `halted` = 1 next cycle. `halt_req` = 0 → mode 001.
- Eight flushes with `EPOCH_W` = 3 → `epoch` wraps 7→0. `rst` asserted mid-FLUSH → all outputs at reset values next cycle.
- With `PIPE_CTRL_PERF_EN`: 5 stall cycles plus 2 flushes → `perf_stall_cnt` = 5 and `perf_flush_cnt` = 2.
